// File: rtl/tnet_pkg.sv
// tnet_pkg: header layout and FIFO entry format shared by the tnet command queue.
// The entry carries a capture timestamp only when TNET_CMD_TSTAMP_EN is defined.
package tnet_pkg;
  localparam int TNET_FLAG_SYNC = 5;
  typedef struct packed {
    logic [3:0]  rsvd;
    logic [3:0]  op;
    logic [5:0]  flags;
    logic [9:0]  dst;
    logic [9:0]  src;
    logic [9:0]  step;
    logic [19:0] arg;
  } tnet_hdr_t;
  typedef struct packed {
    tnet_hdr_t   hdr;
    logic [63:0] data;
`ifdef TNET_CMD_TSTAMP_EN
    logic [31:0] tstamp;
`endif
  } tnet_entry_t;
endpackage

// File: rtl/tnet_cmd_queue_if.sv
// tnet_cmd_queue_if: valid/ready command stream from the queue to the command processor.
interface tnet_cmd_queue_if;
  logic        valid;
  logic        ready;
  logic [3:0]  op;
  logic [5:0]  flags;
  logic [9:0]  dst;
  logic [9:0]  src;
  logic [9:0]  step;
  logic [19:0] arg;
  logic [63:0] data;
  logic [31:0] tstamp;
  modport master (output valid, op, flags, dst, src, step, arg, data, tstamp, input ready);
  modport slave  (input valid, op, flags, dst, src, step, arg, data, tstamp, output ready);
endinterface

// File: rtl/tnet_sync_fifo.sv
// tnet_sync_fifo: single-clock first-word-fall-through FIFO with wrap-bit pointers.
module tnet_sync_fifo #(
  parameter int DW    = 128,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DW-1:0]          din,
  output logic [DW-1:0]          dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic do_push, do_pop;
  always_comb begin
    empty = wr_q == rd_q;
    full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_pop = pop & ~empty;
    do_push = push & (~full | do_pop);
    wr_d = wr_q + {{AW{1'b0}}, do_push};
    rd_d = rd_q + {{AW{1'b0}}, do_pop};
    level = wr_q - rd_q;
    dout = mem_q[rd_q[AW-1:0]];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/tnet_cmd_queue.sv
// tnet_cmd_queue: captures link command requests on their rising edge, buffers and decodes them.
// Define TNET_CMD_TSTAMP_EN to attach a free-running capture timestamp to every entry.
module tnet_cmd_queue
  import tnet_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DROP_W = 8
) (
  input  logic                    user_clk_i,
  input  logic                    user_rst_i,
  input  logic                    cmd_req_i,
  input  logic [63:0]             cmd_i [2],
  input  logic                    clr_stats_i,
  tnet_cmd_queue_if.master        m_cmd,
  output logic [15:0]             rx_cnt_o,
  output logic [DROP_W-1:0]       drop_cnt_o,
  output logic                    overflow_o,
  output logic [$clog2(DEPTH):0]  level_o
);
  localparam int DW = $bits(tnet_entry_t);
  tnet_entry_t din, head;
  logic req_q, req_d, overflow_q, overflow_d;
  logic push, pop, accept, full, empty, unused_rsvd;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
`ifdef TNET_CMD_TSTAMP_EN
  logic [31:0] ts_q, ts_d;
`endif
  always_comb begin
    req_d = cmd_req_i;
    push = cmd_req_i & ~req_q;
    pop = ~empty & m_cmd.ready;
    accept = push & (~full | pop);
    rx_cnt_d = clr_stats_i ? '0 : rx_cnt_q + {15'd0, accept};
    drop_cnt_d = clr_stats_i ? '0 : (push & ~accept & ~&drop_cnt_q) ? drop_cnt_q + DROP_W'(1) : drop_cnt_q;
    overflow_d = ~clr_stats_i & (overflow_q | (push & ~accept));
    din.hdr = cmd_i[0];
    din.data = cmd_i[1];
`ifdef TNET_CMD_TSTAMP_EN
    ts_d = ts_q + 32'd1;
    din.tstamp = ts_q;
    m_cmd.tstamp = head.tstamp;
`else
    m_cmd.tstamp = 32'd0;
`endif
    m_cmd.valid = ~empty;
    m_cmd.op = head.hdr.op;
    m_cmd.flags = head.hdr.flags;
    m_cmd.dst = head.hdr.dst;
    m_cmd.src = head.hdr.src;
    m_cmd.step = head.hdr.step;
    m_cmd.arg = head.hdr.arg;
    m_cmd.data = head.data;
    unused_rsvd = ^head.hdr.rsvd;
    rx_cnt_o = rx_cnt_q;
    drop_cnt_o = drop_cnt_q;
    overflow_o = overflow_q;
  end
  always_ff @(posedge user_clk_i) begin
    if (user_rst_i) begin
      req_q <= 1'b0;
      rx_cnt_q <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      req_q <= req_d;
      rx_cnt_q <= rx_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end
`ifdef TNET_CMD_TSTAMP_EN
  always_ff @(posedge user_clk_i) begin
    if (user_rst_i) ts_q <= '0;
    else ts_q <= ts_d;
  end
`endif
  tnet_sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk   (user_clk_i),
    .rst   (user_rst_i),
    .push  (accept),
    .pop   (pop),
    .din   (din),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level_o)
  );
endmodule

// File: tb/tb_tnet_cmd_queue.sv
// tb_tnet_cmd_queue: directed and random checks of tnet_cmd_queue against a queue-based model.
module tb_tnet_cmd_queue;
  localparam int DEPTH = 16;
  typedef struct packed {
    logic [63:0] hdr;
    logic [63:0] data;
    logic [31:0] ts;
  } ent_t;
  logic clk = 1'b0, rst, req, clr;
  logic [63:0] cmd [2];
  logic [15:0] rx;
  logic [7:0] drop;
  logic ovf;
  logic [4:0] level;
  logic [186:0] dut_vec;
  tnet_cmd_queue_if i ();
  tnet_cmd_queue #(.DEPTH(DEPTH), .DROP_W(8)) dut (
    .user_clk_i  (clk),
    .user_rst_i  (rst),
    .cmd_req_i   (req),
    .cmd_i       (cmd),
    .clr_stats_i (clr),
    .m_cmd       (i),
    .rx_cnt_o    (rx),
    .drop_cnt_o  (drop),
    .overflow_o  (ovf),
    .level_o     (level)
  );
  always #5 clk = ~clk;
  ent_t q[$];
  int total = 0, bad = 0;
  logic [15:0] m_rx;
  logic [7:0] m_drop;
  logic m_ovf, prev;
  logic [31:0] cyc;
  assign dut_vec = {i.valid, level, rx, drop, ovf,
                    i.valid ? {i.op, i.flags, i.dst, i.src, i.step, i.arg, i.data, i.tstamp} : 156'd0};
  function automatic logic [186:0] exp_vec();
    ent_t e;
    logic [31:0] ts;
    e = '0;
    if (q.size() != 0) e = q[0];
`ifdef TNET_CMD_TSTAMP_EN
    ts = e.ts;
`else
    ts = 32'd0;
`endif
    return {q.size() != 0, 5'(q.size()), m_rx, m_drop, m_ovf,
            q.size() != 0 ? {e.hdr[59:0], e.data, ts} : 156'd0};
  endfunction
  // Advance the model by the current inputs, then clock the DUT and settle.
  task automatic tick();
    bit edge_, pop, acc;
    if (rst) begin
      q.delete();
      m_rx = 0;
      m_drop = 0;
      m_ovf = 0;
      prev = 0;
      cyc = 0;
    end else begin
      edge_ = req && !prev;
      pop = q.size() != 0 && i.ready;
      acc = edge_ && (q.size() < DEPTH || pop);
      if (pop) void'(q.pop_front());
      if (acc) q.push_back({cmd[0], cmd[1], cyc});
      if (clr) begin
        m_rx = 0;
        m_drop = 0;
        m_ovf = 0;
      end else begin
        if (acc) m_rx++;
        if (edge_ && !acc) begin
          if (m_drop != 8'hFF) m_drop++;
          m_ovf = 1;
        end
      end
      prev = req;
      cyc++;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic pulse(input logic [63:0] d);
    cmd[0] = {$urandom, $urandom};
    cmd[1] = d;
    req = 1;
    tick();
    req = 0;
    tick();
  endtask
  task automatic test_reset();
    rst = 1; req = 0; clr = 0; i.ready = 0; cmd[0] = '0; cmd[1] = '0;
    tick();
    tick();
    total++;
    if ({i.valid, level, rx, drop, ovf} !== 31'd0) begin
      bad++;
      $display("FAIL reset_state got=%h want=0", {i.valid, level, rx, drop, ovf});
    end
    total++;
    if (dut_vec !== exp_vec()) begin bad++; $display("FAIL reset_model got=%h want=%h", dut_vec, exp_vec()); end
    rst = 0;
  endtask
  task automatic test_single();
    cmd[0] = 64'h0A4C_0802_0030_1234;
    cmd[1] = 64'hDEAD_BEEF_0000_0001;
    req = 1;
    i.ready = 1;
    tick();
    total++;
    if (i.valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", i.valid); end
    // dst/src below are header bits [49:40] and [39:30] of the stimulus word
    total++;
    if ({i.op, i.flags, i.dst, i.src, i.step, i.arg} !== {4'hA, 6'h13, 10'h008, 10'h008, 10'h003, 20'h01234}) begin
      bad++;
      $display("FAIL single_decode got=%h want=%h", {i.op, i.flags, i.dst, i.src, i.step, i.arg},
               {4'hA, 6'h13, 10'h008, 10'h008, 10'h003, 20'h01234});
    end
    total++;
    if ({i.data, rx} !== {64'hDEAD_BEEF_0000_0001, 16'd1}) begin
      bad++;
      $display("FAIL single_data_rx got=%h/%0d want=deadbeef00000001/1", i.data, rx);
    end
    req = 0;
    tick();
    total++;
    if (dut_vec !== exp_vec()) begin bad++; $display("FAIL single_pop got=%h want=%h", dut_vec, exp_vec()); end
  endtask
  task automatic test_hold();
    clr = 1; i.ready = 0;
    tick();
    clr = 0;
    cmd[0] = {$urandom, $urandom};
    cmd[1] = {$urandom, $urandom};
    req = 1;
    for (int c = 0; c < 5; c++) begin
      tick();
      total++;
      if (level > 1 || dut_vec !== exp_vec()) begin
        bad++;
        $display("FAIL hold c=%0d got=%h want=%h", c, dut_vec, exp_vec());
      end
    end
    total++;
    if ({rx, level} !== {16'd1, 5'd1}) begin bad++; $display("FAIL hold_once rx=%0d level=%0d want=1/1", rx, level); end
    req = 0; i.ready = 1;
    tick();
    i.ready = 0;
  endtask
  task automatic test_overflow();
    for (int k = 0; k < DEPTH + 3; k++) pulse(64'(k));
    total++;
    if ({level, drop, ovf} !== {5'(DEPTH), 8'd3, 1'b1}) begin
      bad++;
      $display("FAIL ovf_stats got=%0d/%0d/%b want=%0d/3/1", level, drop, ovf, DEPTH);
    end
    clr = 1;
    tick();
    clr = 0;
    total++;
    if ({rx, drop, ovf, level} !== {16'd0, 8'd0, 1'b0, 5'(DEPTH)}) begin
      bad++;
      $display("FAIL ovf_clear got=%0d/%0d/%b/%0d want=0/0/0/%0d", rx, drop, ovf, level, DEPTH);
    end
    i.ready = 1;
    for (int k = 0; k < DEPTH; k++) begin
      total++;
      if (dut_vec !== exp_vec() || i.data !== 64'(k)) begin
        bad++;
        $display("FAIL ovf_drain k=%0d got=%h want=%h", k, dut_vec, exp_vec());
      end
      tick();
    end
    i.ready = 0;
    total++;
    if ({i.valid, level} !== 6'd0) begin bad++; $display("FAIL ovf_empty got=%b/%0d want=0/0", i.valid, level); end
  endtask
  task automatic test_full_pop_push();
    logic [7:0] d0;
    for (int k = 0; k < DEPTH; k++) pulse(64'(100 + k));
    d0 = drop;
    cmd[1] = 64'hFEED;
    req = 1; i.ready = 1;
    tick();
    req = 0; i.ready = 0;
    total++;
    if ({level, drop} !== {5'(DEPTH), d0}) begin
      bad++;
      $display("FAIL full_poppush level=%0d drop=%0d want=%0d/%0d", level, drop, DEPTH, d0);
    end
    total++;
    if (dut_vec !== exp_vec()) begin bad++; $display("FAIL full_poppush_model got=%h want=%h", dut_vec, exp_vec()); end
    tick();
    i.ready = 1;
    for (int k = 0; k < DEPTH; k++) begin
      tick();
      total++;
      if (dut_vec !== exp_vec()) begin bad++; $display("FAIL full_drain k=%0d got=%h want=%h", k, dut_vec, exp_vec()); end
    end
    i.ready = 0;
  endtask
  task automatic test_wrap();
    i.ready = 1;
    for (int k = 0; k < 3 * DEPTH; k++) begin
      cmd[0] = {$urandom, $urandom};
      cmd[1] = 64'(1000 + k);
      req = 1;
      tick();
      total++;
      if (dut_vec !== exp_vec() || i.data !== 64'(1000 + k)) begin
        bad++;
        $display("FAIL wrap_push k=%0d got=%h want=%h", k, dut_vec, exp_vec());
      end
      req = 0;
      tick();
      total++;
      if (dut_vec !== exp_vec()) begin bad++; $display("FAIL wrap_idle k=%0d got=%h want=%h", k, dut_vec, exp_vec()); end
    end
    i.ready = 0;
  endtask
  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst = $urandom_range(0, 249) == 0;
      clr = $urandom_range(0, 39) == 0;
      if (!req) begin
        cmd[0] = {$urandom, $urandom};
        cmd[1] = {$urandom, $urandom};
      end
      req = $urandom_range(0, 1);
      i.ready = c < 300 ? $urandom_range(0, 4) == 0 : $urandom_range(0, 2) != 0;
      tick();
      total++;
      if (dut_vec !== exp_vec()) begin bad++; $display("FAIL random c=%0d got=%h want=%h", c, dut_vec, exp_vec()); end
    end
    rst = 0; clr = 0; req = 0; i.ready = 0;
  endtask
  task automatic test_tstamp();
    logic [31:0] t1, w1, wd;
`ifdef TNET_CMD_TSTAMP_EN
    w1 = 32'd10;
    wd = 32'd15;
`else
    w1 = 32'd0;
    wd = 32'd0;
`endif
    rst = 1; req = 0; i.ready = 0;
    tick();
    rst = 0;
    for (int c = 0; c < 27; c++) begin
      req = c == 10 || c == 25;
      if (req) cmd[0] = {$urandom, $urandom};
      tick();
    end
    req = 0;
    total++;
    if (i.tstamp !== w1 || dut_vec !== exp_vec()) begin
      bad++;
      $display("FAIL tstamp_first got=%0d want=%0d", i.tstamp, w1);
    end
    t1 = i.tstamp;
    i.ready = 1;
    tick();
    i.ready = 0;
    total++;
    if (i.tstamp - t1 !== wd || dut_vec !== exp_vec()) begin
      bad++;
      $display("FAIL tstamp_delta got=%0d want=%0d", i.tstamp - t1, wd);
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_hold();
    test_overflow();
    test_full_pop_push();
    test_wrap();
    test_random();
    test_tstamp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
